ball_engine: RTL and testbench

Parametrised successor to the single-speed pong ball: moves a square ball across the playfield, bounces it off the top/bottom walls and both paddles, detects misses and reports scoring. All logic runs in the `clk` domain, with a prescaler tick used as an enable rather than a derived clock. A serve state machine, speed-up on paddle hits and explicit score/hit event pulses are added for the scoreboard and sound blocks.

---
 rtl/ball_engine.sv | 205 ++++++++++++++++++++
 tb/tb_ball_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ball_engine.sv
// Pong ball engine: serve sequencing, wall and paddle bounces, speed-up on hits,
// and one-clk score/hit events. Movement advances only on prescaler ticks.
module ball_engine #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BALL_HALF   = 5,
   parameter int PAD_HALF    = 20,
   parameter int LEFT_PAD_X  = 100,
   parameter int RIGHT_PAD_X = 540,
   parameter int TICK_DIV    = 131072,
   parameter int MAX_SPEED   = 4,
   parameter int SERVE_TICKS = 64
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] left_paddle_pos,
   input  logic [9:0] right_paddle_pos,
   input  logic       serve,
   output logic [9:0] ball_x_pos,
   output logic [9:0] ball_y_pos,
   output logic       active,
   output logic [2:0] speed,
   output logic       hit_evt,
   output logic       left_score_evt,
   output logic       right_score_evt
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = $clog2(SERVE_TICKS + 1);

   localparam logic [9:0]         CX   = 10'(SCREEN_W / 2);
   localparam logic [9:0]         CY   = 10'(SCREEN_H / 2);
   localparam logic [10:0]        BH   = 11'(BALL_HALF);
   localparam logic [10:0]        W1   = 11'(SCREEN_W - 1);
   localparam logic [10:0]        H1   = 11'(SCREEN_H - 1);
   localparam logic [10:0]        RPX  = 11'(RIGHT_PAD_X);
   localparam logic [10:0]        LPX  = 11'(LEFT_PAD_X);
   localparam logic signed [10:0] NEAR = 11'(PAD_HALF + BALL_HALF);

   typedef enum logic [1:0] {S_IDLE, S_SERVE_WAIT, S_PLAY, S_SCORED} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [SW-1:0]   cnt_q, cnt_d;
   logic [9:0]      x_q, x_d, y_q, y_d;
   logic            dx_q, dx_d, dy_q, dy_d;   // 1 = right / down
   logic [2:0]      speed_q, speed_d;
   logic            hit_q, hit_d, ls_q, ls_d, rs_q, rs_d;

   logic            tick, miss, near_r, near_l;
   logic [10:0]     x11, y11, spd11, nx_r;
   logic signed [10:0] dr, dl;
   logic [9:0]      y_mv;
   logic            dy_mv;
   logic [2:0]      speed_up;

   always_comb begin
      tick     = (presc_q == PW'(TICK_DIV - 1));
      presc_d  = tick ? '0 : presc_q + 1'b1;
      x11      = {1'b0, x_q};
      y11      = {1'b0, y_q};
      spd11    = {8'd0, speed_q};
      nx_r     = x11 + spd11;
      // Signed distance so paddles near row 0 cannot underflow into a false miss.
      dr       = $signed(y11) - $signed({1'b0, right_paddle_pos});
      dl       = $signed(y11) - $signed({1'b0, left_paddle_pos});
      near_r   = (dr <= NEAR) && (dr >= -NEAR);
      near_l   = (dl <= NEAR) && (dl >= -NEAR);
      speed_up = (speed_q >= 3'(MAX_SPEED)) ? 3'(MAX_SPEED) : speed_q + 3'd1;

      y_mv  = y_q;
      dy_mv = dy_q;
      if (dy_q) begin
         if (y11 + 11'd1 + BH >= H1) begin
            y_mv  = 10'(H1 - BH);
            dy_mv = 1'b0;
         end else begin
            y_mv = y_q + 10'd1;
         end
      end else begin
         if (y11 < BH + 11'd1) begin
            y_mv  = 10'(BALL_HALF);
            dy_mv = 1'b1;
         end else begin
            y_mv = y_q - 10'd1;
         end
      end

      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      speed_d = speed_q;
      hit_d   = 1'b0;
      ls_d    = 1'b0;
      rs_d    = 1'b0;
      miss    = 1'b0;

      case (state_q)
         S_IDLE: begin
            x_d = CX;
            y_d = CY;
            if (serve) begin
               state_d = S_SERVE_WAIT;
               cnt_d   = '0;
            end
         end
         S_SERVE_WAIT: begin
            if (tick) begin
               if (cnt_q == SW'(SERVE_TICKS - 1)) begin
                  state_d = S_PLAY;
                  speed_d = 3'd1;
                  dy_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_PLAY: begin
            if (tick) begin
               // Paddle capture is edge-crossing only, so a ball already past a face is never re-captured.
               if (dx_q) begin
                  if ((x11 + BH < RPX) && (nx_r + BH >= RPX) && near_r) begin
                     x_d     = 10'(RPX - BH - 11'd1);
                     dx_d    = 1'b0;
                     speed_d = speed_up;
                     hit_d   = 1'b1;
                  end else if (nx_r + BH >= W1) begin
                     miss = 1'b1;
                     ls_d = 1'b1;
                  end else begin
                     x_d = x_q + {7'd0, speed_q};
                  end
               end else begin
                  if ((x11 > LPX + BH) && (x11 <= LPX + BH + spd11) && near_l) begin
                     x_d     = 10'(LPX + BH + 11'd1);
                     dx_d    = 1'b1;
                     speed_d = speed_up;
                     hit_d   = 1'b1;
                  end else if (x11 < spd11 + BH + 11'd1) begin
                     miss = 1'b1;
                     rs_d = 1'b1;
                  end else begin
                     x_d = x_q - {7'd0, speed_q};
                  end
               end
               if (miss) begin
                  state_d = S_SCORED;
               end else begin
                  y_d  = y_mv;
                  dy_d = dy_mv;
               end
            end
         end
         S_SCORED: begin
            x_d     = CX;
            y_d     = CY;
            speed_d = 3'd1;
            dx_d    = ~ls_q;
            dy_d    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         cnt_q   <= '0;
         x_q     <= CX;
         y_q     <= CY;
         dx_q    <= 1'b1;
         dy_q    <= 1'b1;
         speed_q <= 3'd1;
         hit_q   <= 1'b0;
         ls_q    <= 1'b0;
         rs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         speed_q <= speed_d;
         hit_q   <= hit_d;
         ls_q    <= ls_d;
         rs_q    <= rs_d;
      end
   end

   assign ball_x_pos      = x_q;
   assign ball_y_pos      = y_q;
   assign active          = (state_q == S_SERVE_WAIT) || (state_q == S_PLAY);
   assign speed           = speed_q;
   assign hit_evt         = hit_q;
   assign left_score_evt  = ls_q;
   assign right_score_evt = rs_q;

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: integer reference model of the ball rules, compared
// against every output after every clock edge, with directed and random phases.
module tb_ball_engine;

   localparam int TD = 4;
   localparam int ST = 2;

   logic       clk;
   logic       reset_n;
   logic [9:0] left_paddle_pos, right_paddle_pos;
   logic       serve;
   logic [9:0] ball_x_pos, ball_y_pos;
   logic       active;
   logic [2:0] speed;
   logic       hit_evt, left_score_evt, right_score_evt;

   int errors = 0;
   int checks = 0;

   // reference model: phase 0 idle, 1 serve wait, 2 play, 3 scored
   int mx, my, mdx, mdy, mspd, mcnt, pc, mph;
   bit mlast_left, mhit, ml, mr;

   ball_engine #(.TICK_DIV(TD), .SERVE_TICKS(ST)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .left_paddle_pos  (left_paddle_pos),
      .right_paddle_pos (right_paddle_pos),
      .serve            (serve),
      .ball_x_pos       (ball_x_pos),
      .ball_y_pos       (ball_y_pos),
      .active           (active),
      .speed            (speed),
      .hit_evt          (hit_evt),
      .left_score_evt   (left_score_evt),
      .right_score_evt  (right_score_evt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic logic [9:0] track(input int y, input int off);
      int v;
      v = y + off;
      if (v < 0) v = 0;
      if (v > 479) v = 479;
      return 10'(v);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mx = 320; my = 240; mdx = 1; mdy = 1; mspd = 1; mcnt = 0; pc = 0; mph = 0;
      mlast_left = 0; mhit = 0; ml = 0; mr = 0;
   endtask

   task automatic play_tick();
      int  nx, ny, ndy;
      bit  miss;
      nx = mx + mdx * mspd;
      ny = my + mdy;
      ndy = mdy;
      if (mdy > 0 && ny + 5 >= 479) begin ny = 474; ndy = -1; end
      else if (mdy < 0 && my < 6) begin ny = 5; ndy = 1; end
      miss = 0;
      if (mdx > 0) begin
         if (mx + 5 < 540 && nx + 5 >= 540 && iabs(my - int'(right_paddle_pos)) <= 25) begin
            mx = 534; mdx = -1; mspd = (mspd + 1 > 4) ? 4 : mspd + 1; mhit = 1;
         end else if (nx + 5 >= 639) begin
            ml = 1; miss = 1; mlast_left = 1;
         end else mx = nx;
      end else begin
         if (mx - 5 > 100 && nx - 5 <= 100 && iabs(my - int'(left_paddle_pos)) <= 25) begin
            mx = 106; mdx = 1; mspd = (mspd + 1 > 4) ? 4 : mspd + 1; mhit = 1;
         end else if (nx < 6) begin
            mr = 1; miss = 1; mlast_left = 0;
         end else mx = nx;
      end
      if (miss) mph = 3;
      else begin my = ny; mdy = ndy; end
   endtask

   task automatic model_edge();
      bit tick;
      tick = (pc == TD - 1);
      pc = (pc + 1) % TD;
      mhit = 0; ml = 0; mr = 0;
      case (mph)
         0: if (serve) begin mph = 1; mcnt = 0; end
         1: if (tick) begin
               if (mcnt == ST - 1) begin mph = 2; mspd = 1; mdy = 1; end
               else mcnt++;
            end
         2: if (tick) play_tick();
         default: begin
            mx = 320; my = 240; mspd = 1; mdx = mlast_left ? -1 : 1; mdy = 1; mph = 0;
         end
      endcase
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".x"}, 16'(ball_x_pos), 16'(mx));
      chk({tag, ".y"}, 16'(ball_y_pos), 16'(my));
      chk({tag, ".active"}, 16'(active), 16'(mph == 1 || mph == 2));
      chk({tag, ".speed"}, 16'(speed), 16'(mspd));
      chk({tag, ".hit"}, 16'(hit_evt), 16'(mhit));
      chk({tag, ".lscore"}, 16'(left_score_evt), 16'(ml));
      chk({tag, ".rscore"}, 16'(right_score_evt), 16'(mr));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      bit seen;
      reset_n = 1'b0;
      serve = 1'b0;
      left_paddle_pos = 10'd240;
      right_paddle_pos = 10'd240;
      model_reset();
      #12 check_all("in_reset");
      #11 reset_n = 1'b1;
      #1 check_all("reset_release");

      // serve and first play ticks
      serve = 1'b1;
      step("serve");
      serve = 1'b0;
      for (int i = 0; i < 40; i++) step("serve_wait");

      // long rally with tracking paddles; serve pokes during play are ignored
      for (int i = 0; i < 5000; i++) begin
         left_paddle_pos  = track(my, int'($urandom_range(0, 30)) - 15);
         right_paddle_pos = track(my, int'($urandom_range(0, 30)) - 15);
         serve = ($urandom_range(0, 7) == 0);
         step("rally");
      end
      serve = 1'b0;
      chk("speed_sat", 16'(speed), 16'd4);

      // right paddle parked away from the ball: left player must score
      seen = 0;
      for (int i = 0; i < 4000 && !seen; i++) begin
         left_paddle_pos  = track(my, 0);
         right_paddle_pos = (my > 240) ? 10'd20 : 10'd460;
         step("right_miss");
         seen = seen | left_score_evt;
      end
      chk("left_score_seen", 16'(seen), 16'd1);
      step("scored");
      step("post_score");

      // async reset in the middle of play
      serve = 1'b1;
      step("serve2");
      serve = 1'b0;
      for (int i = 0; i < 300; i++) begin
         left_paddle_pos  = track(my, 0);
         right_paddle_pos = track(my, 0);
         step("pre_reset");
      end
      chk("active_before_reset", 16'(active), 16'd1);
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_all("async_reset");
      @(posedge clk);
      #3 reset_n = 1'b1;
      model_reset();
      #1 check_all("reset_release2");

      // random play; left paddle pinned near the top to exercise small positions
      for (int i = 0; i < 15000; i++) begin
         left_paddle_pos  = (my < 40) ? 10'd3 : track(my, int'($urandom_range(0, 60)) - 30);
         right_paddle_pos = track(my, int'($urandom_range(0, 60)) - 30);
         serve = ($urandom_range(0, 7) == 0);
         step("random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
